striping_nlane: RTL and testbench
=================================

Name: striping_nlane

Overview:
Parametrised successor to the 2-lane striping stage. Distributes a single valid-qualified word stream at clk_2f round-robin across NUM_LANES output lanes. The active lane count is runtime-selectable, so degraded-width links are supported. Sits between the byte-unstriping/parallel front end and the per-lane serialisers; one word in per cycle, one lane written per cycle.

Parameters:
DATA_W, 32, width of data_in and of each lane word
NUM_LANES, 4, number of physical lanes; legal range 2..8
(derived, not overridable: PTR_W = clog2(NUM_LANES), CNT_W = clog2(NUM_LANES)+1)

Ports:
clk_2f  input  1  single clock; all logic rising-edge
reset  input  1  asynchronous, active-low reset
data_in  input  DATA_W  input word
valid_in  input  1  data_in valid this cycle
active_lanes  input  CNT_W  requested lane count 1..NUM_LANES
flush  input  1  synchronous abort of the current group
lane_out  output  NUM_LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
valid_out  output  NUM_LANES  one-hot per-lane write strobe
group_done  output  1  pulse: last lane of a group written
ptr  output  PTR_W  lane that the next accepted word goes to
partial_err  output  1  pulse: flush discarded a partial group

Behaviour:
- Reset (reset=0, async): lane_out=0, valid_out=0, group_done=0, partial_err=0, ptr=0, internal cur_lanes=NUM_LANES. Reset mid-group discards the partial group with no error pulse.
- Sanitise: active_lanes of 0 or greater than NUM_LANES is treated as NUM_LANES.
- Accept: an edge with valid_in=1 and flush=0 writes data_in into lane ptr. Latency is 1: the word is on lane_out[ptr], with valid_out[ptr]=1, in the next cycle only.
- valid_out is 0 in any cycle following an edge with no accept. lane_out holds its last written value; it is never cleared except by reset.
- Group length: when a word is accepted with ptr==0, cur_lanes is loaded with the sanitised active_lanes. That value governs the whole group, including this first word. active_lanes changes at any other time take effect at the next group start.
- ptr advances by 1 per accepted word and wraps to 0 after lane (group length - 1). With a group length of 1, ptr stays at 0. ptr holds across valid_in=0 bubbles.
- group_done is high in the same cycle as valid_out of the group's last lane, for exactly one cycle.
- flush=1 has priority over valid_in: any word presented in that cycle is dropped.
  - Next cycle: ptr=0, valid_out=0, group_done=0.
  - partial_err=1 for one cycle if ptr was nonzero at the flush edge, else 0.
  - lane_out is retained.
- No backpressure: valid_in is accepted every cycle it is high.

Optional Feature:
STRIPING_PARITY_EN
- Defined: adds output lane_par [NUM_LANES-1:0]. lane_par[i] is the even parity (XOR reduction) of the word written to lane i, registered alongside lane_out. It holds with lane_out and resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- NUM_LANES=4, DATA_W=32: hold reset=0 then release -> all outputs 0, ptr=0; assert reset low mid-group -> outputs 0 immediately, without waiting for a clock edge.
- active_lanes=4, words 0xA0..0xA7 back-to-back -> valid_out 0001,0010,0100,1000 repeating; lane0=0xA0 then 0xA4, lane3=0xA3 then 0xA7; group_done high with the 0xA3 and 0xA7 strobes.
- active_lanes=4, valid_in pattern 1,0,0,1 with 0x11,0x22 -> 0x11 on lane0, valid_out=0 during the gap, 0x22 on lane1; ptr holds at 1 during the gap.
- Two words accepted, then active_lanes changed 4->2 -> the current group still ends on lane3; next group writes lanes 0,1 only, with group_done on each lane1 write.
- Three words accepted, then flush=1 with valid_in=1 and data 0x55 -> 0x55 dropped, partial_err pulses once, next word goes to lane0; flush at ptr=0 -> no partial_err.
- active_lanes=0 -> behaves as 4 lanes; active_lanes=1 -> every word on lane0, group_done each word. With STRIPING_PARITY_EN defined, word 0x00000007 -> lane_par[0]=1.

Source files
------------

// File: rtl/striping_nlane.sv
// Round-robin word striper: one valid-qualified word stream spread across up to NUM_LANES lanes.
// Optional STRIPING_PARITY_EN adds a registered per-lane even-parity output lane_par.
module striping_nlane #(
  parameter  int DATA_W    = 32,
  parameter  int NUM_LANES = 4,
  localparam int PTR_W     = $clog2(NUM_LANES),
  localparam int CNT_W     = $clog2(NUM_LANES) + 1
) (
  input  logic                          clk_2f,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          valid_in,
  input  logic [CNT_W-1:0]              active_lanes,
  input  logic                          flush,
  output logic [NUM_LANES*DATA_W-1:0]   lane_out,
  output logic [NUM_LANES-1:0]          valid_out,
  output logic                          group_done,
  output logic [PTR_W-1:0]              ptr,
`ifdef STRIPING_PARITY_EN
  output logic [NUM_LANES-1:0]          lane_par,
`endif
  output logic                          partial_err
);

  function automatic logic [CNT_W-1:0] sanitise_lanes(input logic [CNT_W-1:0] req);
    if (req == '0 || req > CNT_W'(NUM_LANES))
      return CNT_W'(NUM_LANES);
    return req;
  endfunction

  logic [NUM_LANES-1:0][DATA_W-1:0] lane_p1;
  logic [NUM_LANES-1:0]             vld_p1;
  logic                             done_p1;
  logic                             perr_p1;
  logic [PTR_W-1:0]                 ptr_q;
  logic [CNT_W-1:0]                 cur_lanes;

  // Stage p0: group length is latched only when a group starts, so a word at ptr 0 sees the new value.
  logic [CNT_W-1:0] grp_len_p0;
  logic             last_p0;
  logic             accept_p0;

  assign grp_len_p0 = (ptr_q == '0) ? sanitise_lanes(active_lanes) : cur_lanes;
  assign last_p0    = ({1'b0, ptr_q} == (grp_len_p0 - CNT_W'(1)));
  assign accept_p0  = valid_in && !flush;

  // Stage p1: registered lane words and strobes.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      lane_p1   <= '0;
      vld_p1    <= '0;
      done_p1   <= 1'b0;
      perr_p1   <= 1'b0;
      ptr_q     <= '0;
      cur_lanes <= CNT_W'(NUM_LANES);
    end else if (flush) begin
      vld_p1  <= '0;
      done_p1 <= 1'b0;
      perr_p1 <= (ptr_q != '0);
      ptr_q   <= '0;
    end else if (accept_p0) begin
      lane_p1[ptr_q] <= data_in;
      vld_p1         <= NUM_LANES'(1) << ptr_q;
      done_p1        <= last_p0;
      perr_p1        <= 1'b0;
      ptr_q          <= last_p0 ? '0 : ptr_q + PTR_W'(1);
      if (ptr_q == '0)
        cur_lanes <= grp_len_p0;
    end else begin
      vld_p1  <= '0;
      done_p1 <= 1'b0;
      perr_p1 <= 1'b0;
    end
  end

`ifdef STRIPING_PARITY_EN
  logic [NUM_LANES-1:0] par_p1;

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset)
      par_p1 <= '0;
    else if (accept_p0)
      par_p1[ptr_q] <= ^data_in;
  end

  assign lane_par = par_p1;
`endif

  assign lane_out    = lane_p1;
  assign valid_out   = vld_p1;
  assign group_done  = done_p1;
  assign partial_err = perr_p1;
  assign ptr         = ptr_q;

endmodule

// File: tb/tb_striping_nlane.sv
// Scoreboard bench for striping_nlane (NUM_LANES=4, DATA_W=32) with directed vectors.
module tb_striping_nlane;

  localparam int DW = 32;
  localparam int NL = 4;

  logic            clk_2f;
  logic            reset;
  logic [DW-1:0]   data_in;
  logic            valid_in;
  logic [2:0]      active_lanes;
  logic            flush;
  logic [NL*DW-1:0] lane_out;
  logic [NL-1:0]   valid_out;
  logic            group_done;
  logic [1:0]      ptr;
  logic            partial_err;
`ifdef STRIPING_PARITY_EN
  logic [NL-1:0]   lane_par;
`endif

  striping_nlane #(.DATA_W(DW), .NUM_LANES(NL)) dut (
    .clk_2f(clk_2f),
    .reset(reset),
    .data_in(data_in),
    .valid_in(valid_in),
    .active_lanes(active_lanes),
    .flush(flush),
    .lane_out(lane_out),
    .valid_out(valid_out),
    .group_done(group_done),
    .ptr(ptr),
`ifdef STRIPING_PARITY_EN
    .lane_par(lane_par),
`endif
    .partial_err(partial_err)
  );

  typedef struct {
    logic [NL-1:0] vo;
    logic          gd;
    logic          pe;
    int            lane;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle with a strobe or pulse on the outputs consumes one expected record.
  always @(negedge clk_2f) begin
    if (reset && (valid_out != '0 || group_done || partial_err)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon_unexpected actual_vo=%b actual_pe=%b required=none", valid_out, partial_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_valid_out", 64'(valid_out), 64'(e.vo));
        chk("mon_group_done", 64'(group_done), 64'(e.gd));
        chk("mon_partial_err", 64'(partial_err), 64'(e.pe));
        if (e.vo != '0)
          chk($sformatf("mon_lane%0d", e.lane), 64'(lane_out[e.lane*DW +: DW]), 64'(e.data));
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input bit v, input bit f, input int al,
                      input logic [NL-1:0] evo, input bit egd, input bit epe, input int eptr);
    exp_t e;
    data_in      = d;
    valid_in     = v;
    flush        = f;
    active_lanes = 3'(al);
    if (evo != '0 || egd || epe) begin
      e.vo = evo; e.gd = egd; e.pe = epe; e.data = d; e.lane = 0;
      for (int i = 0; i < NL; i++) if (evo[i]) e.lane = i;
      sb.push_back(e);
    end
    @(posedge clk_2f);
    #1;
    chk("ptr", 64'(ptr), 64'(eptr));
    chk("valid_out", 64'(valid_out), 64'(evo));
  endtask

  function automatic logic [DW-1:0] lane(input int i);
    return lane_out[i*DW +: DW];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; data_in = '0; valid_in = 1'b0; flush = 1'b0; active_lanes = 3'd4;
    repeat (3) @(posedge clk_2f);
    #1;
    chk("rst_lane_out", 64'(lane_out == '0), 64'd1);
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_group_done", 64'(group_done), 64'd0);
    chk("rst_partial_err", 64'(partial_err), 64'd0);
    chk("rst_ptr", 64'(ptr), 64'd0);
    reset = 1'b1;
    @(posedge clk_2f);
    #1;
    chk("post_rst_idle_ptr", 64'(ptr), 64'd0);

    // Full-width groups back to back.
    send(32'hA0, 1, 0, 4, 4'b0001, 0, 0, 1);
    send(32'hA1, 1, 0, 4, 4'b0010, 0, 0, 2);
    send(32'hA2, 1, 0, 4, 4'b0100, 0, 0, 3);
    send(32'hA3, 1, 0, 4, 4'b1000, 1, 0, 0);
    send(32'hA4, 1, 0, 4, 4'b0001, 0, 0, 1);
    send(32'hA5, 1, 0, 4, 4'b0010, 0, 0, 2);
    send(32'hA6, 1, 0, 4, 4'b0100, 0, 0, 3);
    send(32'hA7, 1, 0, 4, 4'b1000, 1, 0, 0);
    chk("lane0_after_A", 64'(lane(0)), 64'hA4);
    chk("lane3_after_A", 64'(lane(3)), 64'hA7);

    // Bubbles: ptr holds, valid_out drops.
    send(32'h11, 1, 0, 4, 4'b0001, 0, 0, 1);
    send(32'hEE, 0, 0, 4, 4'b0000, 0, 0, 1);
    send(32'hEE, 0, 0, 4, 4'b0000, 0, 0, 1);
    send(32'h22, 1, 0, 4, 4'b0010, 0, 0, 2);
    chk("lane0_held", 64'(lane(0)), 64'h11);
    send(32'h33, 1, 0, 4, 4'b0100, 0, 0, 3);
    send(32'h44, 1, 0, 4, 4'b1000, 1, 0, 0);

    // Lane count change mid-group only takes effect at the next group.
    send(32'hB0, 1, 0, 4, 4'b0001, 0, 0, 1);
    send(32'hB1, 1, 0, 4, 4'b0010, 0, 0, 2);
    send(32'hB2, 1, 0, 2, 4'b0100, 0, 0, 3);
    send(32'hB3, 1, 0, 2, 4'b1000, 1, 0, 0);
    send(32'hB4, 1, 0, 2, 4'b0001, 0, 0, 1);
    send(32'hB5, 1, 0, 2, 4'b0010, 1, 0, 0);
    send(32'hB6, 1, 0, 2, 4'b0001, 0, 0, 1);
    send(32'hB7, 1, 0, 2, 4'b0010, 1, 0, 0);

    // Flush with a partial group, then flush at a group boundary.
    send(32'hC0, 1, 0, 4, 4'b0001, 0, 0, 1);
    send(32'hC1, 1, 0, 4, 4'b0010, 0, 0, 2);
    send(32'hC2, 1, 0, 4, 4'b0100, 0, 0, 3);
    send(32'h55, 1, 1, 4, 4'b0000, 0, 1, 0);
    chk("lane3_retained", 64'(lane(3)), 64'hB3);
    send(32'hC3, 1, 0, 4, 4'b0001, 0, 0, 1);
    chk("partial_err_one_cycle", 64'(partial_err), 64'd0);
    send(32'hC4, 1, 0, 4, 4'b0010, 0, 0, 2);
    send(32'hC5, 1, 0, 4, 4'b0100, 0, 0, 3);
    send(32'hC6, 1, 0, 4, 4'b1000, 1, 0, 0);
    send(32'h66, 1, 1, 4, 4'b0000, 0, 0, 0);
    chk("flush_ptr0_no_err", 64'(partial_err), 64'd0);
    chk("lane0_not_0x66", 64'(lane(0)), 64'hC3);

    // Sanitised counts: 0 and 7 act as 4; 1 keeps everything on lane 0.
    send(32'hD0, 1, 0, 0, 4'b0001, 0, 0, 1);
    send(32'hD1, 1, 0, 0, 4'b0010, 0, 0, 2);
    send(32'hD2, 1, 0, 0, 4'b0100, 0, 0, 3);
    send(32'hD3, 1, 0, 0, 4'b1000, 1, 0, 0);
    send(32'hD4, 1, 0, 7, 4'b0001, 0, 0, 1);
    send(32'hD5, 1, 0, 7, 4'b0010, 0, 0, 2);
    send(32'hD6, 1, 0, 7, 4'b0100, 0, 0, 3);
    send(32'hD7, 1, 0, 7, 4'b1000, 1, 0, 0);
    send(32'hE0, 1, 0, 1, 4'b0001, 1, 0, 0);
    send(32'hE1, 1, 0, 1, 4'b0001, 1, 0, 0);
    send(32'h00000007, 1, 0, 1, 4'b0001, 1, 0, 0);
`ifdef STRIPING_PARITY_EN
    chk("lane_par0_odd", 64'(lane_par[0]), 64'd1);
`endif
    send(32'h00000003, 1, 0, 1, 4'b0001, 1, 0, 0);
`ifdef STRIPING_PARITY_EN
    chk("lane_par0_even", 64'(lane_par[0]), 64'd0);
`endif
    chk("lane1_held", 64'(lane(1)), 64'hD5);

    // Asynchronous reset in the middle of a group.
    send(32'hF0, 1, 0, 4, 4'b0001, 0, 0, 1);
    send(32'hF1, 1, 0, 4, 4'b0010, 0, 0, 2);
    valid_in = 1'b0;
    @(negedge clk_2f);
    #1;
    reset = 1'b0;
    #1;
    chk("async_rst_lane_out", 64'(lane_out == '0), 64'd1);
    chk("async_rst_ptr", 64'(ptr), 64'd0);
    chk("async_rst_valid_out", 64'(valid_out), 64'd0);
    #1;
    reset = 1'b1;
    @(posedge clk_2f);
    #1;
    send(32'h77, 1, 0, 4, 4'b0001, 0, 0, 1);
    valid_in = 1'b0;
    @(negedge clk_2f);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
